run_length_detector: RTL and testbench
======================================

// Module: run_length_detector
// PURPOSE
//  Parametrised run detector on a serial bit stream w: tracks current run of equal
//  bits, flags runs of RUN_LEN or more 0s and/or 1s, counts detections.
//  Generalises the fixed 4-bit run FSM: programmable length, qualifier (en),
//  per-polarity mode, saturating run counter, hit pulse and hit counter.
//  Sits between a bit-serial source and control/status logic.
// PARAMETERS
//  RUN_LEN  4  run length that triggers detection; legal range 2..(2**CNT_W-1)
//  CNT_W    4  width of run-length counter (saturates at 2**CNT_W-1)
//  HIT_W    8  width of detection counter (wraps)
// PORTS
//  clk      in   1      clock, all state updates on rising edge
//  reset    in   1      synchronous, active-high; highest priority
//  en       in   1      sample qualifier; w sampled only when en=1
//  w        in   1      serial data bit
//  clear    in   1      sync clear of run tracking (hit_cnt kept)
//  mode     in   2      00 off, 01 detect 0-runs, 10 detect 1-runs, 11 both
//  z        out  1      registered: current run qualifies (len>=RUN_LEN, polarity enabled)
//  hit      out  1      one-cycle pulse when run length reaches exactly RUN_LEN
//  run_val  out  1      polarity of current run (0 in IDLE)
//  run_len  out  CNT_W  length of current run, saturating
//  hit_cnt  out  HIT_W  number of hits since reset, wraps to 0
//  state    out  3      one-hot: IDLE=3'b001, RUN0=3'b010, RUN1=3'b100
// BEHAVIOUR
//  - Reset (sync): state=IDLE, run_len=0, run_val=0, z=0, hit=0, hit_cnt=0.
//  - Priority per edge: reset > clear > en. en=0 and no clear: all regs hold, hit=0.
//  - clear=1: state=IDLE, run_len=0, run_val=0, z=0, hit=0; hit_cnt holds; w ignored.
//  - FSM on valid sample (en=1):
//      IDLE -> RUN0 if w=0 / RUN1 if w=1; run_len=1.
//      RUNx, w==x -> stay; run_len=min(run_len+1, 2**CNT_W-1).
//      RUNx, w!=x -> RUN(w); run_len=1.
//  - run_val follows state (RUN1 -> 1, else 0).
//  - Latency: z/hit/run_len reflect the sample taken on the same edge (1 reg stage);
//    z computed from next-state values: z = (run_len_next>=RUN_LEN) & mode[run_val_next].
//  - z updates only on valid samples; mode change while en=0 has no effect until next sample.
//  - hit=1 only on the edge where run_len_next==RUN_LEN and run_len!=RUN_LEN, polarity
//    enabled by mode; never re-fires during saturation or continued run. Default 0.
//  - hit_cnt increments by 1 with each hit; 2**HIT_W-1 + 1 wraps to 0.
//  - Run broken exactly at RUN_LEN-1: no hit, z=0, new run starts at 1.
//  - mode=00: z=0 and hit=0 always; run tracking continues normally.
//  - Illegal state encoding (non one-hot) recovers to IDLE on next edge.
// TESTING
//  1. RUN_LEN=4, mode=11, en=1, w=1,1,1,1 -> run_len 1,2,3,4; after 4th edge z=1,
//     hit=1 for one cycle, hit_cnt=1, state=3'b100.
//  2. Continue w=1 for 20 more samples (CNT_W=4) -> run_len saturates at 15, z stays 1,
//     no further hit; then w=0 -> run_len=1, state=3'b010, z=0.
//  3. mode=01: four 1s -> z=0, hit never; then four 0s -> z=1, hit once, hit_cnt+1.
//  4. en pattern 1,0,1,0,1,0,1 with w=0 throughout -> run_len advances only on en=1
//     edges (1,1,2,2,3,3,4); hit on 7th edge; w toggles while en=0 are ignored.
//  5. clear at run_len=3 -> IDLE, run_len=0, z=0, hit_cnt unchanged; reset and clear
//     same edge -> hit_cnt=0 (reset wins); reset during saturated run -> all outputs reset.
//  6. HIT_W=2: generate 4 separate qualifying runs -> hit_cnt 1,2,3,0.

Source files
------------

// File: rtl/run_length_detector_if.sv
// Bundles the bit-stream inputs and the status outputs of the run-length detector.
// The source/controller side uses master; the detector uses slave.
interface run_length_detector_if #(
   parameter int CNT_W = 4,
   parameter int HIT_W = 8
);
   logic             en;
   logic             w;
   logic             clear;
   logic [1:0]       mode;
   logic             z;
   logic             hit;
   logic             run_val;
   logic [CNT_W-1:0] run_len;
   logic [HIT_W-1:0] hit_cnt;
   logic [2:0]       state;

   modport master (
      output en, w, clear, mode,
      input  z, hit, run_val, run_len, hit_cnt, state
   );

   modport slave (
      input  en, w, clear, mode,
      output z, hit, run_val, run_len, hit_cnt, state
   );
endinterface

// File: rtl/run_length_detector.sv
// Tracks the current run of equal bits on a qualified serial stream, flags runs of
// RUN_LEN or more for the polarities enabled by mode, and counts detections.
module run_length_detector #(
   parameter int RUN_LEN = 4,
   parameter int CNT_W   = 4,
   parameter int HIT_W   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   run_length_detector_if.slave bus
);
   localparam logic [2:0]       IDLE    = 3'b001;
   localparam logic [2:0]       RUN0    = 3'b010;
   localparam logic [2:0]       RUN1    = 3'b100;
   localparam logic [CNT_W-1:0] LEN_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LEN_HIT = CNT_W'(RUN_LEN);
   localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);

   logic [2:0]       state_q,  state_d;
   logic [CNT_W-1:0] runLen_q, runLen_d;
   logic             z_q,      z_d;
   logic             hit_q,    hit_d;
   logic [HIT_W-1:0] hitCnt_q, hitCnt_d;

   logic             stateLegal;
   logic             continuing;
   logic [CNT_W-1:0] lenNext;
   logic             polarityOn;

   // Every valid sample lands in RUN(w); only the length depends on whether
   // the sample extends the current run or starts a new one.
   always_comb begin
      stateLegal = (state_q == IDLE) || (state_q == RUN0) || (state_q == RUN1);
      continuing = ((state_q == RUN1) && bus.w) || ((state_q == RUN0) && !bus.w);
      if (!continuing) begin
         lenNext = LEN_ONE;
      end else if (runLen_q == LEN_MAX) begin
         lenNext = runLen_q;
      end else begin
         lenNext = runLen_q + LEN_ONE;
      end
      polarityOn = bus.mode[bus.w];
   end

   // Clear and illegal-state recovery both return to IDLE; hit_cnt survives both.
   always_comb begin
      state_d  = state_q;
      runLen_d = runLen_q;
      z_d      = z_q;
      hit_d    = 1'b0;
      hitCnt_d = hitCnt_q;
      if (bus.clear || !stateLegal) begin
         state_d  = IDLE;
         runLen_d = '0;
         z_d      = 1'b0;
      end else if (bus.en) begin
         state_d  = bus.w ? RUN1 : RUN0;
         runLen_d = lenNext;
         z_d      = (lenNext >= LEN_HIT) && polarityOn;
         hit_d    = (lenNext == LEN_HIT) && (runLen_q != LEN_HIT) && polarityOn;
         if (hit_d) begin
            hitCnt_d = hitCnt_q + HIT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         runLen_q <= '0;
         z_q      <= 1'b0;
         hit_q    <= 1'b0;
         hitCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         runLen_q <= runLen_d;
         z_q      <= z_d;
         hit_q    <= hit_d;
         hitCnt_q <= hitCnt_d;
      end
   end

   assign bus.state   = state_q;
   assign bus.run_len = runLen_q;
   assign bus.run_val = (state_q == RUN1);
   assign bus.z       = z_q;
   assign bus.hit     = hit_q;
   assign bus.hit_cnt = hitCnt_q;
endmodule

// File: tb/tb_run_length_detector.sv
// Directed bench for run_length_detector: a default-width instance plus a HIT_W=2
// instance sharing the same stimulus to observe hit counter wrap.
module tb_run_length_detector;
   logic clk;
   logic reset;
   int   totalCnt;
   int   badCnt;

   run_length_detector_if #(.CNT_W(4), .HIT_W(8)) bus  ();
   run_length_detector_if #(.CNT_W(4), .HIT_W(2)) bus2 ();

   run_length_detector #(.RUN_LEN(4), .CNT_W(4), .HIT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   run_length_detector #(.RUN_LEN(4), .CNT_W(4), .HIT_W(2)) dutSmall (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2.slave)
   );

   assign bus2.en    = bus.en;
   assign bus2.w     = bus.w;
   assign bus2.clear = bus.clear;
   assign bus2.mode  = bus.mode;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      totalCnt++;
      if (actual !== expected) begin
         badCnt++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Drive one set of inputs, let one rising edge take them, sample just after.
   task automatic applyStimulus(input logic enV, input logic wV, input logic clearV,
                                input logic [1:0] modeV);
      bus.en    = enV;
      bus.w     = wV;
      bus.clear = clearV;
      bus.mode  = modeV;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b11);
      reset = 1'b0;
   endtask

   initial begin
      totalCnt = 0;
      badCnt   = 0;
      reset    = 1'b1;
      bus.en    = 1'b0;
      bus.w     = 1'b0;
      bus.clear = 1'b0;
      bus.mode  = 2'b11;
      @(posedge clk);
      #1;
      doReset();
      checkOutput("rst_state",   int'(bus.state),   3'b001);
      checkOutput("rst_run_len", int'(bus.run_len), 0);
      checkOutput("rst_run_val", int'(bus.run_val), 0);
      checkOutput("rst_z",       int'(bus.z),       0);
      checkOutput("rst_hit",     int'(bus.hit),     0);
      checkOutput("rst_hit_cnt", int'(bus.hit_cnt), 0);

      // Four ones reach RUN_LEN on the fourth edge.
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 2'b11);
         checkOutput("t1_run_len", int'(bus.run_len), i);
         checkOutput("t1_z",       int'(bus.z),       (i == 4) ? 1 : 0);
         checkOutput("t1_hit",     int'(bus.hit),     (i == 4) ? 1 : 0);
      end
      checkOutput("t1_hit_cnt", int'(bus.hit_cnt), 1);
      checkOutput("t1_state",   int'(bus.state),   3'b100);
      checkOutput("t1_run_val", int'(bus.run_val), 1);

      // Continued run saturates at 15 without re-firing hit.
      for (int i = 5; i <= 24; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 2'b11);
         checkOutput("t2_hit", int'(bus.hit), 0);
         checkOutput("t2_z",   int'(bus.z),   1);
      end
      checkOutput("t2_run_len_sat", int'(bus.run_len), 15);
      checkOutput("t2_hit_cnt",     int'(bus.hit_cnt), 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b11);
      checkOutput("t2_break_len",   int'(bus.run_len), 1);
      checkOutput("t2_break_state", int'(bus.state),   3'b010);
      checkOutput("t2_break_z",     int'(bus.z),       0);

      // Only 0-runs enabled.
      doReset();
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 2'b01);
         checkOutput("t3_ones_z",   int'(bus.z),   0);
         checkOutput("t3_ones_hit", int'(bus.hit), 0);
      end
      checkOutput("t3_ones_len", int'(bus.run_len), 4);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 2'b01);
         checkOutput("t3_zeros_hit", int'(bus.hit), (i == 4) ? 1 : 0);
      end
      checkOutput("t3_zeros_z",   int'(bus.z),       1);
      checkOutput("t3_hit_cnt",   int'(bus.hit_cnt), 1);

      // Qualifier: w toggles while en=0 must be ignored.
      doReset();
      begin
         logic [6:0] enPat;
         int         expLen [7];
         enPat  = 7'b1010101;
         expLen = '{1, 1, 2, 2, 3, 3, 4};
         for (int i = 0; i < 7; i++) begin
            applyStimulus(enPat[6-i], enPat[6-i] ? 1'b0 : 1'b1, 1'b0, 2'b11);
            checkOutput("t4_run_len", int'(bus.run_len), expLen[i]);
            checkOutput("t4_hit",     int'(bus.hit),     (i == 6) ? 1 : 0);
         end
      end
      checkOutput("t4_hit_cnt", int'(bus.hit_cnt), 1);

      // Mode change while en=0 does not touch z; next sample uses the new mode.
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b10);
      checkOutput("t4_hold_z", int'(bus.z), 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b10);
      checkOutput("t4_newmode_z", int'(bus.z), 0);

      // Clear at run_len=3 keeps hit_cnt.
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b11);
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b11);
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b11);
      checkOutput("t5_pre_len", int'(bus.run_len), 3);
      applyStimulus(1'b1, 1'b1, 1'b1, 2'b11);
      checkOutput("t5_clr_state",   int'(bus.state),   3'b001);
      checkOutput("t5_clr_len",     int'(bus.run_len), 0);
      checkOutput("t5_clr_z",       int'(bus.z),       0);
      checkOutput("t5_clr_hit_cnt", int'(bus.hit_cnt), 1);

      // Reset and clear together: reset wins, hit_cnt goes to 0.
      reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 2'b11);
      reset = 1'b0;
      checkOutput("t5_rstclr_hit_cnt", int'(bus.hit_cnt), 0);

      // Break at RUN_LEN-1 gives no hit.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 2'b11);
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b11);
      checkOutput("t5_short_len", int'(bus.run_len), 1);
      checkOutput("t5_short_z",   int'(bus.z),       0);
      checkOutput("t5_short_hit_cnt", int'(bus.hit_cnt), 0);

      // mode=00 tracks runs but never flags.
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
         checkOutput("t5_off_z",   int'(bus.z),   0);
         checkOutput("t5_off_hit", int'(bus.hit), 0);
      end
      checkOutput("t5_off_len", int'(bus.run_len), 5);

      // Reset during a saturated run.
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 1'b0, 2'b11);
      checkOutput("t5_sat_len", int'(bus.run_len), 15);
      doReset();
      checkOutput("t5_rst_state", int'(bus.state),   3'b001);
      checkOutput("t5_rst_len",   int'(bus.run_len), 0);
      checkOutput("t5_rst_z",     int'(bus.z),       0);
      checkOutput("t5_rst_val",   int'(bus.run_val), 0);
      checkOutput("t5_rst_cnt",   int'(bus.hit_cnt), 0);

      // Four qualifying runs of alternating polarity; the HIT_W=2 counter wraps.
      begin
         int expSmall [4];
         expSmall = '{1, 2, 3, 0};
         for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) applyStimulus(1'b1, r[0] ? 1'b0 : 1'b1, 1'b0, 2'b11);
            checkOutput("t6_small_hit_cnt", int'(bus2.hit_cnt), expSmall[r]);
         end
      end
      checkOutput("t6_wide_hit_cnt", int'(bus.hit_cnt), 4);

      $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
      $finish;
   end
endmodule
